traffic_safety_monitor: RTL and testbench
=========================================

// Module: traffic_safety_monitor
// PURPOSE
//  Sits directly downstream of traffic_light and consumes its six lamp outputs plus the shared tick.
//  Checks the lamp stream every clk against legality, sequencing and phase-duration rules.
//  Passes lamps through when they are legal; forces all-red and latches a fault code on any violation.
//  Its safe_* outputs are the only lamp signals that drive the physical lamps.
// PARAMETERS
//  G_TICKS    5  required green duration per direction, in ticks
//  Y_TICKS    2  required yellow duration per direction, in ticks
//  CNT_W      4  phase tick counter width; must hold max(G_TICKS,Y_TICKS)+1
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  synchronous reset, active-low (asserted when 0)
//  tick         in   1  one-cycle enable pulse, the same tick that steps traffic_light
//  ns_g/ns_y/ns_r in 1 each  NS lamps from traffic_light
//  ew_g/ew_y/ew_r in 1 each  EW lamps from traffic_light
//  clear_fault  in   1  one-cycle pulse; acknowledges a latched fault
//  safe_ns_g/y/r out 1 each  gated NS lamps
//  safe_ew_g/y/r out 1 each  gated EW lamps
//  fault        out  1  high while in FAULT or RESYNC
//  fault_code   out  3  first violation since last clear: 0 none, 1 conflict, 2 onehot, 3 order, 4 duration
//  viol_cnt     out  8  count of cycles with a detected violation; saturates at 255
// BEHAVIOUR
//  Reset (rst==0 at a clk edge):
//   - state=RUN; fault=0; fault_code=0; viol_cnt=0.
//   - safe_* = all-red (r=1, g=y=0); prev-lamp registers = red; phase counters=0; both directions disarmed.
//  Per-cycle checks on the current inputs (combinational). Priority when several fire: lowest code wins.
//   1 CONFLICT: both directions non-red, i.e. (ns_g|ns_y) & (ew_g|ew_y).
//   2 ONEHOT: either direction does not have exactly one of g/y/r lit.
//   3 ORDER: a direction's lamp changed vs the previous cycle by something other than G->Y, Y->R or R->G.
//   4 DURATION (armed direction only):
//     - on leaving G, phase count != G_TICKS; on leaving Y, phase count != Y_TICKS;
//     - or, while still in G or Y, the count already exceeds the limit (stuck lamp).
//  Phase counters, one per direction:
//   - cleared to 0 on the cycle the lamp changes;
//   - otherwise +1 on each cycle with tick=1; saturate at all-ones;
//   - red duration is not checked.
//  Arming: a direction arms on its first legal lamp change after reset or RESYNC exit.
//   The partial first phase is never duration-checked.
//  FSM:
//   - RUN: no violation -> safe_* <= inputs (1-cycle latency).
//     Violation -> FAULT; fault_code <= code; safe_* <= all-red on that same edge.
//   - FAULT: safe_* all-red; fault_code frozen; clear_fault=1 -> RESYNC.
//   - RESYNC: safe_* all-red; both directions disarmed; fault_code holds.
//     First cycle where inputs pass checks 1-3 and either direction changes lamp -> RUN; fault_code <= 0.
//     A violation here stays in RESYNC and does not overwrite fault_code.
//  Counting and boundary rules:
//   - viol_cnt increments on every cycle with any violation, in any state.
//   - clear_fault outside FAULT is ignored.
//   - clear_fault in the same cycle as a new violation: the clear wins (-> RESYNC); viol_cnt still increments.
//   - rst==0 mid-FAULT or mid-phase returns to the reset state above.
//   - prev-lamp registers update every cycle in all states.
// TESTING
//  T1: normal cycle, tick every 20 clk, NS G5/Y2, EW G5/Y2 for 3 full rounds -> fault=0, viol_cnt=0, safe_* = inputs delayed 1 clk.
//  T2: force ns_g=1 and ew_g=1 for 1 cycle -> next edge fault=1, fault_code=1, all safe_* red; viol_cnt=1.
//  T3: drive ns_g=ns_y=0, ns_r=0 (dark) -> fault_code=2; set all lamps to 1 -> fault_code=1 (priority).
//  T4: NS jumps G->R skipping yellow -> fault_code=3; pulse clear_fault -> RESYNC, safe all-red until next lamp change -> RUN, fault_code=0.
//  T5: armed NS green lasts 6 ticks -> fault_code=4 on the edge after the 6th tick, before NS leaves green.
//  T6: rst=0 held 2 clk while in FAULT -> fault=0, fault_code=0, viol_cnt=0, safe_* all-red; legal stream then runs clean.

Source files
------------

// File: rtl/traffic_safety_monitor.sv
// Lamp-stream guard between traffic_light and the physical lamps: legality, sequencing and phase-duration checks.
// Legal lamps pass through with 1 clk latency; any violation forces all-red and latches the first fault code.
module traffic_safety_monitor #(
    parameter int G_TICKS = 5,
    parameter int Y_TICKS = 2,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ns_g,
    input  logic       ns_y,
    input  logic       ns_r,
    input  logic       ew_g,
    input  logic       ew_y,
    input  logic       ew_r,
    input  logic       clear_fault,
    output logic       safe_ns_g,
    output logic       safe_ns_y,
    output logic       safe_ns_r,
    output logic       safe_ew_g,
    output logic       safe_ew_y,
    output logic       safe_ew_r,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] viol_cnt
);

    typedef enum logic [1:0] {RUN, FAULT, RESYNC} state_t;

    localparam logic [2:0]       LAMP_G = 3'b100;
    localparam logic [2:0]       LAMP_Y = 3'b010;
    localparam logic [2:0]       LAMP_R = 3'b001;
    localparam logic [CNT_W-1:0] G_LIM  = CNT_W'(G_TICKS);
    localparam logic [CNT_W-1:0] Y_LIM  = CNT_W'(Y_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [2:0]       ns_cur, ew_cur, ns_prev, ew_prev;
    logic [2:0]       safe_ns, safe_ew;
    logic [CNT_W-1:0] ns_cnt, ew_cnt;
    logic             ns_armed, ew_armed;
    logic             ns_chg, ew_chg, ns_step_ok, ew_step_ok;
    logic             v_conflict, v_onehot, v_order, v_dur, viol_basic, viol;
    logic [2:0]       code;
    logic             resync_exit;

    function automatic logic is_onehot(input logic [2:0] l);
        return (l == LAMP_G) || (l == LAMP_Y) || (l == LAMP_R);
    endfunction

    function automatic logic step_ok(input logic [2:0] p, input logic [2:0] c);
        return (p == LAMP_G && c == LAMP_Y) || (p == LAMP_Y && c == LAMP_R) ||
               (p == LAMP_R && c == LAMP_G);
    endfunction

    // Leaving a phase checks the exact count; staying in G/Y checks for overrun.
    function automatic logic dur_bad(input logic [2:0] p, input logic [2:0] c,
                                     input logic [CNT_W-1:0] cnt, input logic armed);
        if (!armed)
            return 1'b0;
        if (p != c)
            return (p == LAMP_G && cnt != G_LIM) || (p == LAMP_Y && cnt != Y_LIM);
        return (c == LAMP_G && cnt > G_LIM) || (c == LAMP_Y && cnt > Y_LIM);
    endfunction

    assign ns_cur     = {ns_g, ns_y, ns_r};
    assign ew_cur     = {ew_g, ew_y, ew_r};
    assign ns_chg     = ns_cur != ns_prev;
    assign ew_chg     = ew_cur != ew_prev;
    assign ns_step_ok = step_ok(ns_prev, ns_cur);
    assign ew_step_ok = step_ok(ew_prev, ew_cur);

    assign v_conflict = (ns_g | ns_y) & (ew_g | ew_y);
    assign v_onehot   = !is_onehot(ns_cur) || !is_onehot(ew_cur);
    assign v_order    = (ns_chg && !ns_step_ok) || (ew_chg && !ew_step_ok);
    assign v_dur      = dur_bad(ns_prev, ns_cur, ns_cnt, ns_armed) ||
                        dur_bad(ew_prev, ew_cur, ew_cnt, ew_armed);
    assign viol_basic = v_conflict | v_onehot | v_order;
    assign viol       = viol_basic | v_dur;

    always_comb begin
        code = 3'd0;
        if (v_conflict)    code = 3'd1;
        else if (v_onehot) code = 3'd2;
        else if (v_order)  code = 3'd3;
        else if (v_dur)    code = 3'd4;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (viol) state_nxt = FAULT;
            FAULT:   if (clear_fault) state_nxt = RESYNC;
            RESYNC:  if (!viol_basic && (ns_chg || ew_chg)) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign resync_exit = (state == RESYNC) && (state_nxt == RUN);

    always_ff @(posedge clk) begin
        if (!rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ns_prev    <= LAMP_R;
            ew_prev    <= LAMP_R;
            ns_cnt     <= '0;
            ew_cnt     <= '0;
            ns_armed   <= 1'b0;
            ew_armed   <= 1'b0;
            safe_ns    <= LAMP_R;
            safe_ew    <= LAMP_R;
            fault_code <= 3'd0;
            viol_cnt   <= 8'd0;
        end else begin
            ns_prev <= ns_cur;
            ew_prev <= ew_cur;

            if (ns_chg)                        ns_cnt <= '0;
            else if (tick && ns_cnt != CNT_MAX) ns_cnt <= ns_cnt + 1'b1;
            if (ew_chg)                        ew_cnt <= '0;
            else if (tick && ew_cnt != CNT_MAX) ew_cnt <= ew_cnt + 1'b1;

            // The phase started by the change that leaves RESYNC is complete, so it arms.
            if (state_nxt == RESYNC) begin
                ns_armed <= 1'b0;
                ew_armed <= 1'b0;
            end else begin
                ns_armed <= ns_armed | (ns_chg & ns_step_ok);
                ew_armed <= ew_armed | (ew_chg & ew_step_ok);
            end

            if (state == RUN && !viol) begin
                safe_ns <= ns_cur;
                safe_ew <= ew_cur;
            end else begin
                safe_ns <= LAMP_R;
                safe_ew <= LAMP_R;
            end

            if (state == RUN && viol)
                fault_code <= code;
            else if (resync_exit)
                fault_code <= 3'd0;

            if (viol && viol_cnt != 8'hFF)
                viol_cnt <= viol_cnt + 8'd1;
        end
    end

    assign fault = state != RUN;
    assign {safe_ns_g, safe_ns_y, safe_ns_r} = safe_ns;
    assign {safe_ew_g, safe_ew_y, safe_ew_r} = safe_ew;

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Directed bench for traffic_safety_monitor: normal sequencing plus each violation class and the reset/clear rules.
module tb_traffic_safety_monitor;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       clear_fault = 1'b0;
    logic [2:0] ns = R;
    logic [2:0] ew = R;
    logic       safe_ns_g, safe_ns_y, safe_ns_r, safe_ew_g, safe_ew_y, safe_ew_r;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] viol_cnt;
    logic [2:0] safe_ns, safe_ew;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign safe_ns = {safe_ns_g, safe_ns_y, safe_ns_r};
    assign safe_ew = {safe_ew_g, safe_ew_y, safe_ew_r};

    traffic_safety_monitor #(.G_TICKS(5), .Y_TICKS(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .ns_g(ns[2]), .ns_y(ns[1]), .ns_r(ns[0]),
        .ew_g(ew[2]), .ew_y(ew[1]), .ew_r(ew[0]),
        .clear_fault(clear_fault),
        .safe_ns_g(safe_ns_g), .safe_ns_y(safe_ns_y), .safe_ns_r(safe_ns_r),
        .safe_ew_g(safe_ew_g), .safe_ew_y(safe_ew_y), .safe_ew_r(safe_ew_r),
        .fault(fault), .fault_code(fault_code), .viol_cnt(viol_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c < 20; c++) begin
                tick = (c == 19);
                step();
            end
        end
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; ns = R; ew = R; tick = 1'b0; clear_fault = 1'b0;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({fault, fault_code, viol_cnt, safe_ns, safe_ew} !== {1'b0, 3'd0, 8'd0, R, R})
            $display("FAIL reset_state: got fault=%b code=%0d cnt=%0d ns=%b ew=%b, want 0/0/0/001/001",
                     fault, fault_code, viol_cnt, safe_ns, safe_ew);
        else pass_cnt++;
    endtask

    task automatic test_normal_cycle(input int rounds);
        logic [2:0] ns_seq [4];
        logic [2:0] ew_seq [4];
        int         tk_seq [4];
        ns_seq = '{G, Y, R, R};
        ew_seq = '{R, R, G, Y};
        tk_seq = '{5, 2, 5, 2};
        for (int rd = 0; rd < rounds; rd++) begin
            for (int ph = 0; ph < 4; ph++) begin
                ns = ns_seq[ph];
                ew = ew_seq[ph];
                for (int t = 0; t < tk_seq[ph]; t++) begin
                    for (int c = 0; c < 20; c++) begin
                        tick = (c == 19);
                        step();
                        total_cnt++;
                        if ({fault, safe_ns, safe_ew} !== {1'b0, ns, ew})
                            $display("FAIL pass_through r%0d p%0d: got fault=%b ns=%b ew=%b, want 0 %b %b",
                                     rd, ph, fault, safe_ns, safe_ew, ns, ew);
                        else pass_cnt++;
                    end
                end
            end
        end
        tick = 1'b0;
        total_cnt++;
        if (viol_cnt !== 8'd0) $display("FAIL normal_viol_cnt: got %0d want 0", viol_cnt);
        else pass_cnt++;
    endtask

    task automatic test_conflict();
        do_reset();
        ns = G; step();
        ew = G; step();
        total_cnt++;
        if ({fault, fault_code, viol_cnt, safe_ns, safe_ew} !== {1'b1, 3'd1, 8'd1, R, R})
            $display("FAIL conflict: got fault=%b code=%0d cnt=%0d ns=%b ew=%b, want 1/1/1/001/001",
                     fault, fault_code, viol_cnt, safe_ns, safe_ew);
        else pass_cnt++;
    endtask

    task automatic test_onehot();
        do_reset();
        ns = 3'b000; step();
        total_cnt++;
        if ({fault, fault_code, viol_cnt} !== {1'b1, 3'd2, 8'd1})
            $display("FAIL onehot_dark: got fault=%b code=%0d cnt=%0d want 1/2/1", fault, fault_code, viol_cnt);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({fault_code, viol_cnt} !== {3'd2, 8'd2})
            $display("FAIL onehot_hold: got code=%0d cnt=%0d want 2/2", fault_code, viol_cnt);
        else pass_cnt++;
        repeat (260) step();
        total_cnt++;
        if (viol_cnt !== 8'd255) $display("FAIL viol_cnt_saturate: got %0d want 255", viol_cnt);
        else pass_cnt++;
        do_reset();
        ns = 3'b111; ew = 3'b111; step();
        total_cnt++;
        if ({fault, fault_code} !== {1'b1, 3'd1})
            $display("FAIL priority_all_lit: got fault=%b code=%0d want 1/1", fault, fault_code);
        else pass_cnt++;
    endtask

    task automatic test_order_resync();
        do_reset();
        ns = G; repeat (4) step();
        ns = R; step();
        total_cnt++;
        if ({fault, fault_code, viol_cnt} !== {1'b1, 3'd3, 8'd1})
            $display("FAIL order_skip_y: got fault=%b code=%0d cnt=%0d want 1/3/1", fault, fault_code, viol_cnt);
        else pass_cnt++;
        step();
        clear_fault = 1'b1; ns = 3'b000; step();
        clear_fault = 1'b0;
        total_cnt++;
        if ({fault, fault_code, viol_cnt} !== {1'b1, 3'd3, 8'd2})
            $display("FAIL clear_with_viol: got fault=%b code=%0d cnt=%0d want 1/3/2", fault, fault_code, viol_cnt);
        else pass_cnt++;
        step();
        ns = R; step();
        step();
        total_cnt++;
        if ({fault, fault_code, viol_cnt, safe_ns, safe_ew} !== {1'b1, 3'd3, 8'd4, R, R})
            $display("FAIL resync_hold: got fault=%b code=%0d cnt=%0d ns=%b ew=%b want 1/3/4/001/001",
                     fault, fault_code, viol_cnt, safe_ns, safe_ew);
        else pass_cnt++;
        ns = G; step();
        total_cnt++;
        if ({fault, fault_code, safe_ns} !== {1'b0, 3'd0, R})
            $display("FAIL resync_exit: got fault=%b code=%0d ns=%b want 0/0/001", fault, fault_code, safe_ns);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({safe_ns, safe_ew} !== {G, R})
            $display("FAIL after_resync_pass: got ns=%b ew=%b want 100 001", safe_ns, safe_ew);
        else pass_cnt++;
        clear_fault = 1'b1; step(); clear_fault = 1'b0; step();
        total_cnt++;
        if ({fault, viol_cnt} !== {1'b0, 8'd4})
            $display("FAIL clear_in_run_ignored: got fault=%b cnt=%0d want 0/4", fault, viol_cnt);
        else pass_cnt++;
    endtask

    task automatic test_duration();
        do_reset();
        ns = G; step();
        tick_n(4);
        ns = Y; step();
        total_cnt++;
        if ({fault, fault_code} !== {1'b1, 3'd4})
            $display("FAIL green_short: got fault=%b code=%0d want 1/4", fault, fault_code);
        else pass_cnt++;
        do_reset();
        ns = G; step();
        tick_n(5);
        step();
        total_cnt++;
        if (fault !== 1'b0) $display("FAIL green_at_limit: got fault=%b want 0", fault);
        else pass_cnt++;
        tick_n(1);
        total_cnt++;
        if (fault !== 1'b0) $display("FAIL green_6th_tick_edge: got fault=%b want 0", fault);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({fault, fault_code, safe_ns} !== {1'b1, 3'd4, R})
            $display("FAIL green_stuck: got fault=%b code=%0d ns=%b want 1/4/001", fault, fault_code, safe_ns);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_fault();
        do_reset();
        ns = G; ew = G; step();
        total_cnt++;
        if (fault !== 1'b1) $display("FAIL enter_fault: got fault=%b want 1", fault);
        else pass_cnt++;
        rst = 1'b0; ns = R; ew = R;
        step(); step();
        total_cnt++;
        if ({fault, fault_code, viol_cnt, safe_ns, safe_ew} !== {1'b0, 3'd0, 8'd0, R, R})
            $display("FAIL reset_mid_fault: got fault=%b code=%0d cnt=%0d ns=%b ew=%b want 0/0/0/001/001",
                     fault, fault_code, viol_cnt, safe_ns, safe_ew);
        else pass_cnt++;
        rst = 1'b1;
        test_normal_cycle(1);
    endtask

    initial begin
        test_reset();
        test_normal_cycle(3);
        test_conflict();
        test_onehot();
        test_order_resync();
        test_duration();
        test_reset_in_fault();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
